// File: rtl/rv32i_types.sv
// Shared types and constants for the branch predictor / resolver slice.
package rv32i_types;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned PHT_ENTRIES = 16;
  localparam int unsigned PHT_IDX_W   = 4;
  localparam logic [1:0]  PHT_RESET   = 2'b01;

  // Prediction payload carried alongside an instruction through ID and EX.
  typedef struct packed {
    logic            valid;
    logic            pred_taken;
    logic [XLEN-1:0] pred_pc;
  } bp_stage_t;

  // 2-bit saturating counter step.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken && (ctr != 2'b11)) res = ctr + 2'(1);
    if (!taken && (ctr != 2'b00)) res = ctr - 2'(1);
    return res;
  endfunction

endpackage

// File: rtl/bp_pht.sv
// 16-entry pattern history table of 2-bit saturating counters.
// The read port returns the registered value, so a same-cycle write is not forwarded.
module bp_pht
  import rv32i_types::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PHT_IDX_W-1:0] rd_idx,
  output logic [1:0]           rd_ctr_c,
  input  logic                 wr_en,
  input  logic [PHT_IDX_W-1:0] wr_idx,
  input  logic                 wr_taken
);

  logic [1:0] ctr_q [PHT_ENTRIES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(PHT_ENTRIES); i++) ctr_q[i] <= PHT_RESET;
    end else if (wr_en) begin
      ctr_q[wr_idx] <= sat_update(ctr_q[wr_idx], wr_taken);
    end
  end

  assign rd_ctr_c = ctr_q[rd_idx];

endmodule

// File: rtl/bp_resolve.sv
// Branch prediction at IF and resolution at EX, with PHT training and BTB write-back.
// Optional performance counters are enabled by defining BP_PERF_COUNTERS_EN.
module bp_resolve
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] IF_pc,
  input  logic        btb_hit,
  input  logic [31:0] predicted_pc,
  input  logic        EX_valid,
  input  logic        EX_is_branch,
  input  logic        EX_taken,
  input  logic [31:0] EX_target,
  input  logic [31:0] EX_pc,
  output logic [31:0] next_pc,
  output logic        flush,
  output logic        btb_load,
  output logic [31:0] EX_pc_out,
  output logic [31:0] EX_pc_branch_target
`ifdef BP_PERF_COUNTERS_EN
  ,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
`endif
);

  logic [1:0]  pht_ctr_c;
  logic        pred_taken_c;
  logic [31:0] pred_pc_c;
  logic        mispredict_c;
  logic        pht_upd_c;
  logic        rst_d;
  bp_stage_t   id_q;
  bp_stage_t   ex_q;

  bp_pht u_pht (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (IF_pc[5:2]),
    .rd_ctr_c (pht_ctr_c),
    .wr_en    (pht_upd_c),
    .wr_idx   (EX_pc[5:2]),
    .wr_taken (EX_taken)
  );

  // Prediction, resolution and redirect selection.
  always_comb begin
    pred_taken_c = btb_hit && pht_ctr_c[1];
    pred_pc_c    = pred_taken_c ? predicted_pc : IF_pc + 32'd4;
    mispredict_c = !reset && !stall && EX_valid && ex_q.valid &&
                   ((EX_is_branch && ((ex_q.pred_taken != EX_taken) ||
                                      (EX_taken && (ex_q.pred_pc != EX_target)))) ||
                    (!EX_is_branch && ex_q.pred_taken));
    pht_upd_c    = !reset && !stall && EX_valid && EX_is_branch && ex_q.valid;
    // rst_d keeps the BTB write quiet in the first cycle out of reset.
    btb_load     = !reset && !rst_d && !stall && EX_valid && EX_is_branch && EX_taken;
    flush        = mispredict_c;
    next_pc      = pred_pc_c;
    if (mispredict_c) next_pc = (EX_taken && EX_is_branch) ? EX_target : EX_pc + 32'd4;
  end

  assign EX_pc_out           = EX_pc;
  assign EX_pc_branch_target = EX_target;

  // ID/EX prediction stages; a mispredict squashes both in-flight entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_q  <= '0;
      ex_q  <= '0;
      rst_d <= 1'b1;
    end else begin
      rst_d <= 1'b0;
      if (!stall) begin
        id_q <= '{valid: !mispredict_c, pred_taken: pred_taken_c, pred_pc: pred_pc_c};
        ex_q <= '{valid: id_q.valid && !mispredict_c, pred_taken: id_q.pred_taken,
                  pred_pc: id_q.pred_pc};
      end
    end
  end

`ifdef BP_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (pht_upd_c)    branch_count     <= branch_count + 32'd1;
      if (mispredict_c) mispredict_count <= mispredict_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_resolve.sv
// Scoreboard bench for bp_resolve: driver queues expected outputs, monitor checks at negedge.
module tb_bp_resolve;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] IF_pc = '0;
  logic        btb_hit = 1'b0;
  logic [31:0] predicted_pc = '0;
  logic        EX_valid = 1'b0;
  logic        EX_is_branch = 1'b0;
  logic        EX_taken = 1'b0;
  logic [31:0] EX_target = '0;
  logic [31:0] EX_pc = '0;
  logic [31:0] next_pc;
  logic        flush;
  logic        btb_load;
  logic [31:0] EX_pc_out;
  logic [31:0] EX_pc_branch_target;
`ifdef BP_PERF_COUNTERS_EN
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;
`endif

  bp_resolve dut (
    .clk                 (clk),
    .reset               (reset),
    .stall               (stall),
    .IF_pc               (IF_pc),
    .btb_hit             (btb_hit),
    .predicted_pc        (predicted_pc),
    .EX_valid            (EX_valid),
    .EX_is_branch        (EX_is_branch),
    .EX_taken            (EX_taken),
    .EX_target           (EX_target),
    .EX_pc               (EX_pc),
    .next_pc             (next_pc),
    .flush               (flush),
    .btb_load            (btb_load),
    .EX_pc_out           (EX_pc_out),
    .EX_pc_branch_target (EX_pc_branch_target)
`ifdef BP_PERF_COUNTERS_EN
    ,
    .branch_count        (branch_count),
    .mispredict_count    (mispredict_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stl;
    logic [31:0] ifpc;
    logic        hit;
    logic [31:0] ppc;
    logic        exv, exb, ext;
    logic [31:0] tgt, expc;
    logic [31:0] e_npc;
    logic        e_fl, e_bl;
    int          cnt_chk;
    logic [31:0] e_bc, e_mc;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] npc;
    logic        fl, bl;
    logic [31:0] expc, tgt;
    int          cnt_chk;
    logic [31:0] bc, mc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  bit   done = 1'b0;
  int   tests = 0;
  int   fails = 0;

  task automatic add(input logic rst, input logic stl, input logic [31:0] ifpc, input logic hit,
                     input logic [31:0] ppc, input logic exv, input logic exb, input logic ext,
                     input logic [31:0] tgt, input logic [31:0] expc, input logic [31:0] e_npc,
                     input logic e_fl, input logic e_bl, input int cnt_chk = 0,
                     input logic [31:0] e_bc = 0, input logic [31:0] e_mc = 0);
    vec_t v;
    v = '{rst, stl, ifpc, hit, ppc, exv, exb, ext, tgt, expc, e_npc, e_fl, e_bl,
          cnt_chk, e_bc, e_mc};
    vecs.push_back(v);
  endtask

  // Driver: one vector per cycle, applied just after the rising edge.
  initial begin
    //   rst stl IF_pc        hit pred   exv exb ext tgt    expc    next_pc    fl bl
    add(1, 0, 32'h60,       1, 32'h100, 1, 1, 1, 32'h100, 32'h60,  32'h64,    0, 0); // reset
    add(0, 0, 32'h60,       1, 32'h100, 1, 1, 1, 32'h100, 32'h60,  32'h64,    0, 0); // post-reset quiet
    add(0, 0, 32'h64,       0, 32'h0,   0, 0, 0, 32'h0,   32'h0,   32'h68,    0, 0);
    add(0, 0, 32'h68,       0, 32'h0,   1, 1, 1, 32'h100, 32'h60,  32'h100,   1, 1); // mispredict 1
    add(0, 0, 32'h100,      0, 32'h0,   1, 0, 0, 32'h0,   32'h68,  32'h104,   0, 0);
    add(0, 0, 32'h60,       0, 32'h0,   0, 0, 0, 32'h0,   32'h0,   32'h64,    0, 0);
    add(0, 0, 32'h64,       0, 32'h0,   1, 0, 0, 32'h0,   32'h100, 32'h68,    0, 0);
    add(0, 0, 32'h68,       0, 32'h0,   1, 1, 1, 32'h100, 32'h60,  32'h100,   1, 1); // mispredict 2
    add(0, 0, 32'h60,       1, 32'h100, 0, 0, 0, 32'h0,   32'h0,   32'h100,   0, 0); // PHT[8]=3
    add(0, 0, 32'h100,      0, 32'h0,   0, 0, 0, 32'h0,   32'h0,   32'h104,   0, 0);
    add(0, 0, 32'h104,      0, 32'h0,   1, 1, 1, 32'h100, 32'h60,  32'h108,   0, 1); // correct
    add(0, 0, 32'h60,       1, 32'h100, 0, 0, 0, 32'h0,   32'h0,   32'h100,   0, 0);
    add(0, 0, 32'h100,      0, 32'h0,   0, 0, 0, 32'h0,   32'h0,   32'h104,   0, 0);
    add(0, 0, 32'h104,      0, 32'h0,   1, 1, 1, 32'h200, 32'h60,  32'h200,   1, 1); // wrong target
    add(0, 0, 32'h60,       1, 32'h100, 0, 0, 0, 32'h0,   32'h0,   32'h100,   0, 0);
    add(0, 0, 32'h100,      0, 32'h0,   0, 0, 0, 32'h0,   32'h0,   32'h104,   0, 0);
    add(0, 0, 32'h104,      0, 32'h0,   1, 0, 0, 32'h0,   32'h80,  32'h84,    1, 0); // non-branch
    add(0, 0, 32'h80,       1, 32'h300, 0, 0, 0, 32'h0,   32'h0,   32'h84,    0, 0); // PHT[0] still 01
    add(0, 0, 32'h60,       1, 32'h100, 0, 0, 0, 32'h0,   32'h0,   32'h100,   0, 0);
    add(0, 0, 32'h100,      0, 32'h0,   0, 0, 0, 32'h0,   32'h0,   32'h104,   0, 0);
    for (int i = 0; i < 3; i++)                                                       // stalled
      add(0, 1, 32'h104,    0, 32'h0,   1, 1, 0, 32'h64,  32'h60,  32'h108,   0, 0);
    add(0, 0, 32'h104,      0, 32'h0,   1, 1, 0, 32'h64,  32'h60,  32'h64,    1, 0); // released
    add(0, 0, 32'h64,       0, 32'h0,   1, 0, 0, 32'h0,   32'h104, 32'h68,    0, 0);
    add(0, 0, 32'h68,       0, 32'h0,   1, 0, 0, 32'h0,   32'h100, 32'h6c,    0, 0);
    add(0, 0, 32'h60,       1, 32'h100, 1, 1, 0, 32'h64,  32'h60,  32'h100,   0, 0); // old value read
    add(0, 0, 32'h60,       1, 32'h100, 0, 0, 0, 32'h0,   32'h0,   32'h64,    0, 0); // PHT[8]=1
    add(0, 0, 32'hFFFFFFFC, 0, 32'h0,   0, 0, 0, 32'h0,   32'h0,   32'h0,     0, 0, 1, 6, 5);
    add(1, 0, 32'h40,       0, 32'h0,   1, 1, 1, 32'h80,  32'h40,  32'h44,    0, 0); // reset wins
    add(0, 0, 32'h60,       1, 32'h100, 1, 1, 1, 32'h80,  32'h40,  32'h64,    0, 0, 1, 0, 0);
    add(0, 0, 32'h44,       0, 32'h0,   1, 1, 1, 32'h80,  32'h40,  32'h48,    0, 1);

    reset = 1'b1;
    @(posedge clk);
    foreach (vecs[i]) begin
      exp_t e;
      @(posedge clk);
      #1;
      reset = vecs[i].rst;        stall = vecs[i].stl;
      IF_pc = vecs[i].ifpc;       btb_hit = vecs[i].hit;      predicted_pc = vecs[i].ppc;
      EX_valid = vecs[i].exv;     EX_is_branch = vecs[i].exb; EX_taken = vecs[i].ext;
      EX_target = vecs[i].tgt;    EX_pc = vecs[i].expc;
      e.name = $sformatf("vec%0d", i);
      e.npc = vecs[i].e_npc;      e.fl = vecs[i].e_fl;        e.bl = vecs[i].e_bl;
      e.expc = vecs[i].expc;      e.tgt = vecs[i].tgt;
      e.cnt_chk = vecs[i].cnt_chk; e.bc = vecs[i].e_bc;       e.mc = vecs[i].e_mc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    EX_valid = 1'b0;
    done = 1'b1;
  end

  // Monitor: pops one expectation per cycle and compares on the falling edge.
  initial begin
    int cycles;
    cycles = 0;
    while ((!done || sb.size() > 0) && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        tests++;
        if (next_pc !== e.npc || flush !== e.fl || btb_load !== e.bl) begin
          fails++;
          $display("FAIL %s: next_pc=%h flush=%b btb_load=%b, want next_pc=%h flush=%b btb_load=%b",
                   e.name, next_pc, flush, btb_load, e.npc, e.fl, e.bl);
        end
        tests++;
        if (EX_pc_out !== e.expc || EX_pc_branch_target !== e.tgt) begin
          fails++;
          $display("FAIL %s_btbport: pc_out=%h target=%h, want %h %h",
                   e.name, EX_pc_out, EX_pc_branch_target, e.expc, e.tgt);
        end
`ifdef BP_PERF_COUNTERS_EN
        if (e.cnt_chk != 0) begin
          tests++;
          if (branch_count !== e.bc || mispredict_count !== e.mc) begin
            fails++;
            $display("FAIL %s_counters: branch=%0d mispredict=%0d, want %0d %0d",
                     e.name, branch_count, mispredict_count, e.bc, e.mc);
          end
        end
`endif
      end
    end
    if (sb.size() > 0 || !done) begin
      tests++;
      fails++;
      $display("FAIL timeout: %0d expectations left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
